bidir_bus_ctrl: RTL and testbench

BIDIR_BUS_CTRL -- requirements
Module: bidir_bus_ctrl

---
 rtl/bidir_bus_ctrl_if.sv | 29 ++
 rtl/bidir_bus_ctrl.sv | 152 +++++++++++++++
 tb/tb_bidir_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bidir_bus_ctrl_if.sv
// Request/response and pad-side signal bundle for bidir_bus_ctrl.
//   req_valid/req_ready/req_wr/req_wdata : request handshake from the client
//   rsp_valid/rsp_rdata                  : read response (no backpressure)
//   pad_o/pad_t/pad_strb/pad_i           : IOB data out, drive enable, strobe, registered data in
// slave modport is the controller's view; master modport is the client/pad view.
interface bidir_bus_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] pad_o;
  logic          pad_t;
  logic [DW-1:0] pad_i;
  logic          pad_strb;

  modport slave (
    input  req_valid, req_wr, req_wdata, pad_i,
    output req_ready, rsp_valid, rsp_rdata, pad_o, pad_t, pad_strb
  );

  modport master (
    output req_valid, req_wr, req_wdata, pad_i,
    input  req_ready, rsp_valid, rsp_rdata, pad_o, pad_t, pad_strb
  );
endinterface

// File: rtl/bidir_bus_ctrl.sv
// Bidirectional pad bus controller: accepts single read/write requests,
// inserts turnaround cycles on direction change, strobes the bus once per
// transfer and captures read data RD_LAT edges after the read strobe.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bidir_bus_ctrl_if.slave (request, response and pad signals)
module bidir_bus_ctrl #(
  parameter int unsigned DW     = 8,
  parameter int unsigned TURN   = 2,
  parameter int unsigned RD_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bidir_bus_ctrl_if.slave bus
);

  localparam int unsigned CW = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TA      = 3'd1;
  localparam logic [2:0] S_WR      = 3'd2;
  localparam logic [2:0] S_RD_STB  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  // Terminal counts; TA_LAST is unused when TURN=0 since TA is then unreachable.
  localparam logic [CW-1:0] TA_LAST = CW'(TURN - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] pad_o_q, pad_o_d;
  logic          pad_t_q, pad_t_d;
  logic          pad_strb_q, pad_strb_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dir_q       <= DIR_RD;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      pad_o_q     <= '0;
      pad_t_q     <= 1'b0;
      pad_strb_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      pad_o_q     <= pad_o_d;
      pad_t_q     <= pad_t_d;
      pad_strb_q  <= pad_strb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state and next-output logic; pad outputs are decoded from state_d so
  // they appear as flop outputs aligned with the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    wdata_d     = wdata_q;
    pad_o_d     = pad_o_q;
    pad_t_d     = pad_t_q;
    pad_strb_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wdata_d = bus.req_wdata;
          dir_d   = bus.req_wr;
          cnt_d   = '0;
          // A read releases the bus right away; a write keeps whatever is driven.
          if (bus.req_wr == DIR_RD) pad_t_d = 1'b0;
          if ((bus.req_wr != dir_q) && (TURN != 0)) state_d = S_TA;
          else if (bus.req_wr == DIR_WR)            state_d = S_WR;
          else                                      state_d = S_RD_STB;
        end
      end
      S_TA: begin
        if (cnt_q == TA_LAST) begin
          cnt_d   = '0;
          state_d = (dir_q == DIR_WR) ? S_WR : S_RD_STB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR: begin
        state_d = S_IDLE;
      end
      S_RD_STB: begin
        if (RD_LAT == 1) begin
          rsp_rdata_d = bus.pad_i;
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          // Counter tracks edges elapsed since RD_STB entry.
          cnt_d   = CW'(1);
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == RD_LAST) begin
          rsp_rdata_d = bus.pad_i;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == S_WR) begin
      pad_strb_d = 1'b1;
      pad_t_d    = 1'b1;
      pad_o_d    = wdata_d;
    end
    if (state_d == S_RD_STB) pad_strb_d = 1'b1;
  end

  assign ready_d = (state_d == S_IDLE);

  assign bus.req_ready = ready_q;
  assign bus.pad_o     = pad_o_q;
  assign bus.pad_t     = pad_t_q;
  assign bus.pad_strb  = pad_strb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Self-checking bench for bidir_bus_ctrl: directed scenarios with literal
// expectations, then randomized traffic with occasional async resets, all
// compared each cycle against a transaction-timing model.
module tb_bidir_bus_ctrl;
  localparam int DW     = 8;
  localparam int TURN   = 2;
  localparam int RD_LAT = 3;

  logic clk;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  bidir_bus_ctrl_if #(.DW(DW)) bus ();

  bidir_bus_ctrl #(.DW(DW), .TURN(TURN), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted request is turned into absolute edge numbers for its
  // strobe, write-drive, capture and return-to-ready events.
  int         n         = 0;
  int         wr_edge   = -1;
  int         strb_edge = -1;
  int         cap_edge  = -1;
  int         free_edge = 0;
  logic       m_ready   = 1'b1;
  logic       m_pad_t   = 1'b0;
  logic       m_strb    = 1'b0;
  logic       m_rsp     = 1'b0;
  logic       m_dir     = 1'b0;
  logic [7:0] m_pad_o   = 8'h00;
  logic [7:0] m_rdata   = 8'h00;
  logic [7:0] pend      = 8'h00;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        wr_edge = -1; strb_edge = -1; cap_edge = -1; free_edge = 0;
        m_ready = 1'b1; m_pad_t = 1'b0; m_strb = 1'b0; m_rsp = 1'b0;
        m_dir = 1'b0; m_pad_o = 8'h00; m_rdata = 8'h00;
      end else begin
        int start;
        n++;
        m_strb = 1'b0;
        m_rsp  = 1'b0;
        if (bus.req_valid && m_ready) begin
          start = n + ((bus.req_wr != m_dir) ? TURN : 0);
          m_dir = bus.req_wr;
          if (bus.req_wr) begin
            pend      = bus.req_wdata;
            wr_edge   = start;
            free_edge = start + 1;
          end else begin
            m_pad_t   = 1'b0;
            strb_edge = start;
            cap_edge  = start + RD_LAT;
            free_edge = cap_edge;
          end
        end
        if (n == wr_edge) begin
          m_pad_t = 1'b1;
          m_pad_o = pend;
          m_strb  = 1'b1;
        end
        if (n == strb_edge) m_strb = 1'b1;
        if (n == cap_edge) begin
          m_rdata = bus.pad_i;
          m_rsp   = 1'b1;
        end
        m_ready = (n >= free_edge);
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("req_ready", 8'(bus.req_ready), 8'(m_ready));
      chk("pad_t",     8'(bus.pad_t),     8'(m_pad_t));
      chk("pad_strb",  8'(bus.pad_strb),  8'(m_strb));
      chk("pad_o",     bus.pad_o,         m_pad_o);
      chk("rsp_valid", 8'(bus.rsp_valid), 8'(m_rsp));
      chk("rsp_rdata", bus.rsp_rdata,     m_rdata);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 8'(bus.req_ready), 8'h1);
    chk({tag, "_pad_t"}, 8'(bus.pad_t),     8'h0);
    chk({tag, "_strb"},  8'(bus.pad_strb),  8'h0);
    chk({tag, "_rsp"},   8'(bus.rsp_valid), 8'h0);
    chk({tag, "_pad_o"}, bus.pad_o,         8'h00);
    chk({tag, "_rdata"}, bus.rsp_rdata,     8'h00);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 32 && !bus.req_ready; i++) @(negedge clk);
    chk("wait_ready", 8'(bus.req_ready), 8'h1);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_wdata = 8'h00; bus.pad_i = 8'h00;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0xA5 after reset: two TA cycles, then one WR cycle.
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_wdata = 8'hA5;
    @(negedge clk); bus.req_valid = 1'b0; bus.req_wdata = 8'h00;
    chk("a5_ta0_ready", 8'(bus.req_ready), 8'h0);
    chk("a5_ta0_pad_t", 8'(bus.pad_t), 8'h0);
    @(negedge clk);
    chk("a5_ta1_ready", 8'(bus.req_ready), 8'h0);
    chk("a5_ta1_strb", 8'(bus.pad_strb), 8'h0);
    @(negedge clk);
    chk("a5_wr_ready", 8'(bus.req_ready), 8'h0);
    chk("a5_wr_pad_t", 8'(bus.pad_t), 8'h1);
    chk("a5_wr_pad_o", bus.pad_o, 8'hA5);
    chk("a5_wr_strb", 8'(bus.pad_strb), 8'h1);
    @(negedge clk);
    chk("a5_done_ready", 8'(bus.req_ready), 8'h1);
    chk("a5_done_strb", 8'(bus.pad_strb), 8'h0);
    chk("a5_done_pad_t", 8'(bus.pad_t), 8'h1);

    // Back-to-back writes 0x11, 0x22 with valid held.
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_wdata = 8'h11;
    @(negedge clk);
    chk("w11_strb", 8'(bus.pad_strb), 8'h1);
    chk("w11_pad_o", bus.pad_o, 8'h11);
    bus.req_wdata = 8'h22;
    @(negedge clk);
    chk("w11_gap_ready", 8'(bus.req_ready), 8'h1);
    chk("w11_gap_strb", 8'(bus.pad_strb), 8'h0);
    chk("w11_gap_pad_t", 8'(bus.pad_t), 8'h1);
    @(negedge clk);
    chk("w22_strb", 8'(bus.pad_strb), 8'h1);
    chk("w22_pad_o", bus.pad_o, 8'h22);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("w22_end_pad_o", bus.pad_o, 8'h22);
    chk("w22_end_pad_t", 8'(bus.pad_t), 8'h1);

    // Read after write with turnaround, pad_i = 0x3C.
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.pad_i = 8'h3C;
    @(negedge clk); bus.req_valid = 1'b0;
    chk("r3c_e0_pad_t", 8'(bus.pad_t), 8'h0);
    @(negedge clk);
    chk("r3c_ta_strb", 8'(bus.pad_strb), 8'h0);
    @(negedge clk);
    chk("r3c_stb_strb", 8'(bus.pad_strb), 8'h1);
    @(negedge clk);
    chk("r3c_w1_rsp", 8'(bus.rsp_valid), 8'h0);
    @(negedge clk);
    chk("r3c_w2_rsp", 8'(bus.rsp_valid), 8'h0);
    @(negedge clk);
    chk("r3c_rsp", 8'(bus.rsp_valid), 8'h1);
    chk("r3c_rdata", bus.rsp_rdata, 8'h3C);
    chk("r3c_ready", 8'(bus.req_ready), 8'h1);

    // Read after read, valid held: no TA, response overlaps next accept.
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.pad_i = 8'h5A;
    @(negedge clk);
    chk("r5a_stb_strb", 8'(bus.pad_strb), 8'h1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("r5a_rsp", 8'(bus.rsp_valid), 8'h1);
    chk("r5a_rdata", bus.rsp_rdata, 8'h5A);
    chk("r5a_ready", 8'(bus.req_ready), 8'h1);
    @(negedge clk);
    chk("r5a_next_acc", 8'(bus.req_ready), 8'h0);
    bus.req_valid = 1'b0;
    wait_ready();

    // Reset pulsed during RD_WAIT, then a write that needs TA and ignores late data changes.
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.pad_i = 8'h77;
    @(negedge clk); bus.req_valid = 1'b0;
    chk("rst_rd_strb", 8'(bus.pad_strb), 8'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid");
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_rsp", 8'(bus.rsp_valid), 8'h0);
    end
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_wdata = 8'h0F;
    @(negedge clk); bus.req_valid = 1'b0; bus.req_wdata = 8'hF0;
    chk("w0f_ta0_pad_t", 8'(bus.pad_t), 8'h0);
    chk("w0f_ta0_ready", 8'(bus.req_ready), 8'h0);
    @(negedge clk);
    chk("w0f_ta1_strb", 8'(bus.pad_strb), 8'h0);
    @(negedge clk);
    chk("w0f_wr_pad_o", bus.pad_o, 8'h0F);
    chk("w0f_wr_strb", 8'(bus.pad_strb), 8'h1);
    chk("w0f_wr_pad_t", 8'(bus.pad_t), 8'h1);
    @(negedge clk);
    chk("w0f_done_ready", 8'(bus.req_ready), 8'h1);

    // Randomized traffic with rare asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      bus.req_valid = ($urandom_range(0, 9) < 7);
      bus.req_wr    = 1'($urandom_range(0, 1));
      bus.req_wdata = 8'($urandom);
      bus.pad_i     = 8'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rnd");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
